// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with same-edge WB write-through and a load-use hazard flag.
// Latency: one cycle from id_* to ex_*; load_use_hazard is combinational.
// Backpressure: stall holds every field; flush loads a bubble and overrides stall.
module id_ex_latch #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [1:0]        id_rs,
    input  logic [1:0]        id_rt,
    input  logic [1:0]        id_rd,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [1:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [1:0]        ex_rs,
    output logic [1:0]        ex_rt,
    output logic [1:0]        ex_rd,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_hazard
);

    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;

    // The register file commits the WB write on the same edge we sample its
    // read ports, so its outputs are stale for a matching index.
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] data1_nxt;
    logic [DATA_W-1:0] data2_nxt;

    assign byp1      = wb_reg_write && (wb_write_reg == id_rs);
    assign byp2      = wb_reg_write && (wb_write_reg == id_rt);
    assign data1_nxt = byp1 ? wb_write_data : id_data1;
    assign data2_nxt = byp2 ? wb_write_data : id_data2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (!stall) begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_data1 <= data1_nxt;
            ex_data2 <= data2_nxt;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    logic ex_is_load;
    logic src_match;

    assign ex_is_load = ex_valid && ex_ctrl[CTRL_MEM_READ] && ex_ctrl[CTRL_REG_WRITE];
    assign src_match  = (id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt));

    assign load_use_hazard = reset_n && ex_is_load && id_valid && src_match;

endmodule

// File: tb/tb_id_ex_latch.sv
// Randomized bench for id_ex_latch against a behavioural model of the pipeline register.
module tb_id_ex_latch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_use_rs, id_use_rt;
    logic [1:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_data1, id_data2, id_imm;
    logic [7:0]  id_ctrl;
    logic        wb_reg_write;
    logic [1:0]  wb_write_reg;
    logic [15:0] wb_write_data;
    logic        stall, flush;
    logic        ex_valid;
    logic [1:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] ex_data1, ex_data2, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        load_use_hazard;

    always #5 clk = ~clk;

    id_ex_latch dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .load_use_hazard(load_use_hazard)
    );

    typedef struct {
        bit        valid;
        bit [1:0]  rs, rt, rd;
        bit [15:0] d1, d2, imm;
        bit [7:0]  ctrl;
    } stage_t;

    stage_t m;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stage_t bubble();
        stage_t s;
        s.valid = 0; s.rs = 0; s.rt = 0; s.rd = 0;
        s.d1 = 0; s.d2 = 0; s.imm = 0; s.ctrl = 0;
        return s;
    endfunction

    // The latch's contract: what EX should see after an edge, given what ID/WB offered.
    function automatic stage_t next_stage(stage_t cur);
        stage_t s;
        if (flush) return bubble();
        if (stall) return cur;
        s.valid = id_valid;
        s.rs = id_rs; s.rt = id_rt; s.rd = id_rd;
        s.imm = id_imm;
        s.ctrl = id_valid ? id_ctrl : 8'h00;
        s.d1 = (wb_reg_write && wb_write_reg == id_rs) ? wb_write_data : id_data1;
        s.d2 = (wb_reg_write && wb_write_reg == id_rt) ? wb_write_data : id_data2;
        return s;
    endfunction

    function automatic bit exp_hazard();
        bit is_load = m.valid && m.ctrl[1] && m.ctrl[0];
        bit hit = (id_use_rs && m.rd == id_rs) || (id_use_rt && m.rd == id_rt);
        return reset_n && is_load && id_valid && hit;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, m.valid});
        chk({tag, ".rs"},    {30'b0, ex_rs},    {30'b0, m.rs});
        chk({tag, ".rt"},    {30'b0, ex_rt},    {30'b0, m.rt});
        chk({tag, ".rd"},    {30'b0, ex_rd},    {30'b0, m.rd});
        chk({tag, ".data1"}, {16'b0, ex_data1}, {16'b0, m.d1});
        chk({tag, ".data2"}, {16'b0, ex_data2}, {16'b0, m.d2});
        chk({tag, ".imm"},   {16'b0, ex_imm},   {16'b0, m.imm});
        chk({tag, ".ctrl"},  {24'b0, ex_ctrl},  {24'b0, m.ctrl});
        chk({tag, ".haz"},   {31'b0, load_use_hazard}, {31'b0, exp_hazard()});
    endtask

    // Inputs are changed at posedge+1 and outputs sampled there too.
    task automatic cycle(input string tag);
        stage_t nx = next_stage(m);
        @(posedge clk);
        #1;
        m = nx;
        check_all(tag);
    endtask

    task automatic set_id(input bit v, input bit [1:0] rs, input bit [1:0] rt, input bit [1:0] rd,
                          input bit [15:0] d1, input bit [15:0] d2, input bit [7:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_data1 = d1; id_data2 = d2; id_ctrl = ctrl;
    endtask

    task automatic randomize_inputs(input int stall_pct, input int flush_pct);
        id_valid = 1'($urandom_range(0, 3) != 0);
        id_rs = 2'($urandom); id_rt = 2'($urandom); id_rd = 2'($urandom);
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        id_data1 = 16'($urandom); id_data2 = 16'($urandom); id_imm = 16'($urandom);
        id_ctrl = 8'($urandom);
        wb_reg_write = 1'($urandom); wb_write_reg = 2'($urandom); wb_write_data = 16'($urandom);
        stall = ($urandom_range(0, 99) < stall_pct);
        flush = ($urandom_range(0, 99) < flush_pct);
    endtask

    initial begin
        reset_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        id_use_rs = 0; id_use_rt = 0; id_imm = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        stall = 0; flush = 0;
        m = bubble();
        #2;
        check_all("reset");
        #20;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Plain load
        set_id(1, 2'd1, 2'd2, 2'd3, 16'h1234, 16'hABCD, 8'h05);
        id_imm = 16'h0042;
        cycle("plain");
        chk("plain.d1_const", {16'b0, ex_data1}, 32'h1234);
        chk("plain.ctrl_const", {24'b0, ex_ctrl}, 32'h05);

        // Async reset mid-cycle with live contents
        #2;
        reset_n = 1'b0;
        #1;
        m = bubble();
        check_all("async_rst");
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Bypass both operands, then a non-matching WB index
        set_id(1, 2'd2, 2'd2, 2'd0, 16'h0000, 16'h0000, 8'h01);
        wb_reg_write = 1; wb_write_reg = 2'd2; wb_write_data = 16'h00FF;
        cycle("byp");
        chk("byp.d1_const", {16'b0, ex_data1}, 32'h00FF);
        chk("byp.d2_const", {16'b0, ex_data2}, 32'h00FF);
        wb_write_reg = 2'd3;
        cycle("nobyp");
        chk("nobyp.d1_const", {16'b0, ex_data1}, 32'h0000);

        // Register 0 bypasses like any other
        set_id(1, 2'd0, 2'd1, 2'd0, 16'h1111, 16'h2222, 8'h01);
        wb_write_reg = 2'd0; wb_write_data = 16'hBEEF;
        cycle("byp_r0");

        // Stall three cycles while everything upstream churns
        set_id(1, 2'd3, 2'd1, 2'd2, 16'h5A5A, 16'hA5A5, 8'h07);
        wb_reg_write = 0;
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(0, 0);
            stall = 1;
            cycle($sformatf("stall%0d", i));
            chk("stall.d1_const", {16'b0, ex_data1}, 32'h5A5A);
        end

        // Flush beats stall
        stall = 1; flush = 1;
        cycle("stall_flush");
        chk("stall_flush.ctrl_const", {24'b0, ex_ctrl}, 32'h00);
        stall = 0; flush = 0;

        // Load-use hazard
        wb_reg_write = 0;
        set_id(1, 2'd0, 2'd0, 2'd1, 16'h0, 16'h0, 8'h03);
        id_use_rs = 0; id_use_rt = 0;
        cycle("ld");
        set_id(1, 2'd1, 2'd2, 2'd0, 16'h0, 16'h0, 8'h01);
        id_use_rs = 1; id_use_rt = 0;
        #1;
        chk("haz.rs", {31'b0, load_use_hazard}, 32'd1);
        id_use_rs = 0;
        #1;
        chk("haz.no_use", {31'b0, load_use_hazard}, 32'd0);
        id_rt = 2'd1; id_use_rt = 1;
        #1;
        chk("haz.rt", {31'b0, load_use_hazard}, 32'd1);
        id_valid = 0;
        #1;
        chk("haz.id_invalid", {31'b0, load_use_hazard}, 32'd0);
        id_valid = 1;
        flush = 1;
        cycle("haz_flush");
        chk("haz.after_flush", {31'b0, load_use_hazard}, 32'd0);
        flush = 0;
        set_id(1, 2'd0, 2'd0, 2'd1, 16'h0, 16'h0, 8'h01);
        cycle("ld_nomem");
        id_rs = 2'd1; id_use_rs = 1;
        #1;
        chk("haz.not_load", {31'b0, load_use_hazard}, 32'd0);

        // Invalid ID clears control
        set_id(0, 2'd1, 2'd2, 2'd3, 16'h7777, 16'h8888, 8'hFF);
        cycle("invalid");
        chk("invalid.ctrl_const", {24'b0, ex_ctrl}, 32'h00);

        // Randomized run, with an occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            randomize_inputs(20, 10);
            if (i % 7 == 0) begin
                id_ctrl[1:0] = 2'b11;
                id_use_rs = 1;
            end
            #1;
            check_all("rnd_comb");
            if (i % 150 == 149) begin
                reset_n = 1'b0;
                #1;
                m = bubble();
                check_all("rnd_rst");
                reset_n = 1'b1;
            end
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register for the 16-bit, 4-register pipelined core; sits directly downstream of the register file.
- Captures the two register-file read values, the immediate, the register indices and the decoded control word, and presents them to EX.
- Provides same-cycle WB write-through bypass, because the register file writes on the same edge this latch samples.
- Supports hold (stall) and bubble insertion (flush), and raises a combinational load-use hazard flag for the upstream hazard/PC logic.

Parameters:
- DATA_W, 16, data path width.
- CTRL_W, 8, decoded control word width; bit0 = reg_write, bit1 = mem_read, remaining bits opaque and passed through.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  2  source register 1 index.
- id_rt  in  2  source register 2 index.
- id_rd  in  2  destination register index, already selected by the decoder.
- id_use_rs  in  1  instruction actually reads rs.
- id_use_rt  in  1  instruction actually reads rt.
- id_data1  in  DATA_W  register file read_out1 (rs).
- id_data2  in  DATA_W  register file read_out2 (rt).
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  decoded control word.
- wb_reg_write  in  1  WB stage writes the register file this cycle.
- wb_write_reg  in  2  WB destination index.
- wb_write_data  in  DATA_W  WB write value.
- stall  in  1  hold all latch contents.
- flush  in  1  load a bubble.
- ex_valid  out  1  latch holds a real instruction.
- ex_rs, ex_rt, ex_rd  out  2 each  latched indices.
- ex_data1, ex_data2  out  DATA_W  latched operands.
- ex_imm  out  DATA_W  latched immediate.
- ex_ctrl  out  CTRL_W  latched control word.
- load_use_hazard  out  1  combinational hazard flag.

Behaviour:
- Reset (reset_n=0, asynchronous): all ex_* outputs clear to 0, including ex_valid=0 and ex_ctrl=0. Asserting reset mid-operation discards the held instruction immediately, without waiting for a clock edge.
- Priority at each rising edge: flush > stall > load.
- Flush: ex_valid←0 and ex_ctrl←0, so the bubble has reg_write=0 and mem_read=0. Data, index and imm fields ←0. A flush overrides a simultaneous stall.
- Stall (flush=0): every register holds its value. wb_* inputs and id_* inputs are ignored.
- Load: ex_valid←id_valid and all id_* fields are captured. If id_valid=0, ex_ctrl←0 regardless of id_ctrl.
- Bypass: on load, ex_data1←wb_write_data when wb_reg_write=1 and wb_write_reg==id_rs; otherwise ex_data1←id_data1. ex_data2 follows the same rule using id_rt. Both operands may bypass in the same cycle. The bypass applies regardless of id_use_rs and id_use_rt. Register 0 is an ordinary register, so bypass applies to it as well.
- Latency: exactly one cycle from ID inputs to ex_* outputs; no other pipelining.
- load_use_hazard is purely combinational and asserts when all of the following hold:
  - ex_valid=1, ex_ctrl[1]=1 and ex_ctrl[0]=1;
  - id_valid=1;
  - (id_use_rs=1 and ex_rd==id_rs) or (id_use_rt=1 and ex_rd==id_rt).
- load_use_hazard is forced to 0 during reset. The block does not act on its own flag; upstream responds by freezing IF/ID and driving flush for one cycle.

Test Plan:
- Reset: pulse reset_n low between clock edges with ex_* previously nonzero -> all outputs 0 immediately, before the next edge; load_use_hazard=0.
- Plain load: id_rs=1, id_rt=2, id_data1=0x1234, id_data2=0xABCD, id_ctrl=0x05, id_valid=1, no WB write -> after one edge ex_data1=0x1234, ex_data2=0xABCD, ex_ctrl=0x05, ex_valid=1.
- Bypass:
  - wb_reg_write=1, wb_write_reg=2, wb_write_data=0x00FF with id_rs=2, id_rt=2, stale id_data1=id_data2=0x0000 -> ex_data1=ex_data2=0x00FF.
  - Repeat with wb_write_reg=3 -> no bypass; ex_data1=ex_data2=0x0000.
- Stall/flush:
  - Hold stall=1 for 3 cycles while id_* and wb_* change -> ex_* unchanged.
  - Assert stall=1 and flush=1 together -> ex_valid=0, ex_ctrl=0x00.
- Load-use hazard:
  - Latch a load (ex_ctrl=0x03, ex_rd=1). Then drive id_rs=1 with id_use_rs=1 -> load_use_hazard=1.
  - With id_use_rs=0 -> 0. With ex_ctrl=0x01 -> 0. After a flush -> 0.
- Invalid ID: id_valid=0, id_ctrl=0xFF -> ex_valid=0, ex_ctrl=0x00.
